// File: rtl/miner_pkg.sv
// Shared definitions for the miner reporting path: nonce geometry,
// default UART bit period and the UART transmitter state encoding.
package miner_pkg;

    // Width of a golden nonce and the number of UART bytes it occupies.
    localparam int NONCE_W         = 32;
    localparam int BYTES_PER_NONCE = 4;

    // hash_clk cycles per UART bit at 100 MHz / 115200 baud.
    localparam int BAUD_DIV_DEFAULT = 868;

    // UART transmitter states. LOAD is a single cycle between the FIFO pop
    // and the first start bit; STOP loops back to START until the last byte.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } uart_state_e;

endpackage

// File: rtl/nonce_fifo.sv
// Small synchronous FIFO holding golden nonces while the UART is busy.
// Read data is show-ahead: rd_data always presents the head entry, so a pop
// and the use of rd_data happen on the same edge.
// A push is honoured when not full, or when full and popped on the same edge;
// a pop is honoured only when not empty.
module nonce_fifo
    import miner_pkg::*;
#(
    parameter int FIFO_LOG2 = 2,
    parameter int WIDTH     = NONCE_W
) (
    input  logic                 hash_clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output logic [FIFO_LOG2:0]   count,
    output logic [WIDTH-1:0]     rd_data
);

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] FULL_COUNT = (FIFO_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage array; written on an accepted push, never reset.
    always_ff @(posedge hash_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally modulo the depth; count tracks occupancy.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/golden_nonce_uart_tx.sv
// Golden-nonce reporter: queues nonce strobes in a FIFO and serialises each
// nonce as four 8N1 UART bytes, most significant byte first, LSB-first bits.
// nonce_valid is a fire-and-forget strobe with no ready: it is accepted when
// the FIFO has room or is popped on the same edge, otherwise it is dropped
// and the sticky overflow flag is raised.
module golden_nonce_uart_tx
    import miner_pkg::*;
#(
    parameter int BAUD_DIV  = BAUD_DIV_DEFAULT,
    parameter int FIFO_LOG2 = 2
) (
    input  logic                 hash_clk,
    input  logic                 reset,
    input  logic                 nonce_valid,
    input  logic [NONCE_W-1:0]   nonce_in,
    output logic                 uart_tx,
    output logic                 busy,
    output logic                 overflow,
    output logic [FIFO_LOG2:0]   fifo_count
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [1:0]       LAST_BYTE = 2'(BYTES_PER_NONCE - 1);

    uart_state_e        state;
    logic [CNT_W-1:0]   baud_cnt;
    logic               baud_wrap;
    logic [2:0]         bit_idx;
    logic [1:0]         byte_idx;
    logic [NONCE_W-1:0] word_sr;
    logic [7:0]         byte_sr;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [NONCE_W-1:0] fifo_rd_data;

    // The head word is taken whenever the transmitter is idle; a push on the
    // same edge is still accepted because the pop frees a slot.
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign fifo_push = nonce_valid && (!fifo_full || fifo_pop);
    assign baud_wrap = (baud_cnt == BAUD_LAST);

    nonce_fifo #(
        .FIFO_LOG2 (FIFO_LOG2),
        .WIDTH     (NONCE_W)
    ) u_fifo (
        .hash_clk (hash_clk),
        .reset    (reset),
        .push     (fifo_push),
        .wr_data  (nonce_in),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .rd_data  (fifo_rd_data)
    );

    // Sticky drop flag: a strobe that finds the FIFO full with no pop is lost.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (nonce_valid && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

    // Transmit FSM with baud counter, word/byte shifters and registered line.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state    <= IDLE;
            uart_tx  <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            word_sr  <= '0;
            byte_sr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    uart_tx  <= 1'b1;
                    if (fifo_pop) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        word_sr  <= fifo_rd_data;
                        byte_idx <= '0;
                    end
                end

                LOAD: begin
                    // First start bit; peel off the most significant byte.
                    state    <= START;
                    uart_tx  <= 1'b0;
                    baud_cnt <= '0;
                    byte_sr  <= word_sr[NONCE_W-1 -: 8];
                    word_sr  <= {word_sr[NONCE_W-9:0], 8'h00};
                end

                START: begin
                    if (baud_wrap) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        uart_tx  <= byte_sr[0];
                        byte_sr  <= {1'b0, byte_sr[7:1]};
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            uart_tx <= byte_sr[0];
                            byte_sr <= {1'b0, byte_sr[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (byte_idx == LAST_BYTE) begin
                            // Word complete: one IDLE cycle precedes any next LOAD.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            // Next byte follows the stop bit with no gap.
                            state    <= START;
                            uart_tx  <= 1'b0;
                            byte_idx <= byte_idx + 1'b1;
                            byte_sr  <= word_sr[NONCE_W-1 -: 8];
                            word_sr  <= {word_sr[NONCE_W-9:0], 8'h00};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Bench for golden_nonce_uart_tx: one instance at BAUD_DIV=4 for the main
// scenarios and one at BAUD_DIV=2 for the back-to-back word gap.
module tb_golden_nonce_uart_tx;

    localparam int BD_A = 4;
    localparam int BD_B = 2;

    logic        hash_clk;
    logic        reset;
    logic        nonce_valid;
    logic [31:0] nonce_in;
    logic        uart_tx;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifo_count;
    logic        nonce_valid2;
    logic [31:0] nonce_in2;
    logic        uart_tx2;
    logic        busy2;
    logic        overflow2;
    logic [2:0]  fifo_count2;

    int          total;
    int          passed;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_a[$];
    logic [7:0]  got_b[$];
    logic        wave[100];

    typedef struct {
        logic [31:0] nonce;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
    } vec_t;
    vec_t vecs[4];

    golden_nonce_uart_tx #(.BAUD_DIV(BD_A), .FIFO_LOG2(2)) dut (
        .hash_clk    (hash_clk),
        .reset       (reset),
        .nonce_valid (nonce_valid),
        .nonce_in    (nonce_in),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .overflow    (overflow),
        .fifo_count  (fifo_count)
    );

    golden_nonce_uart_tx #(.BAUD_DIV(BD_B), .FIFO_LOG2(2)) dut2 (
        .hash_clk    (hash_clk),
        .reset       (reset),
        .nonce_valid (nonce_valid2),
        .nonce_in    (nonce_in2),
        .uart_tx     (uart_tx2),
        .busy        (busy2),
        .overflow    (overflow2),
        .fifo_count  (fifo_count2)
    );

    // Clock and watchdog
    initial begin
        hash_clk = 1'b0;
        forever #5 hash_clk = ~hash_clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic line_of(input int which);
        return (which == 0) ? uart_tx : uart_tx2;
    endfunction

    // UART receiver: decodes 8N1 frames by sampling mid-bit at negedges;
    // a frame overlapped by reset or with a low stop bit is discarded.
    task automatic uart_mon(input int which, input int bd);
        logic [7:0] b;
        bit         abort;
        forever begin
            @(negedge hash_clk);
            if (line_of(which) === 1'b0 && reset !== 1'b1) begin
                b     = '0;
                abort = 1'b0;
                for (int c = 1; c < 10 * bd; c++) begin
                    @(negedge hash_clk);
                    if (reset === 1'b1) abort = 1'b1;
                    if (c >= bd && c < 9 * bd && (c % bd) == bd / 2)
                        b[(c / bd) - 1] = line_of(which);
                    if (c == 9 * bd + bd / 2 && line_of(which) !== 1'b1)
                        abort = 1'b1;
                end
                if (!abort) begin
                    if (which == 0) got_a.push_back(b);
                    else            got_b.push_back(b);
                end
            end
        end
    endtask

    initial uart_mon(0, BD_A);
    initial uart_mon(1, BD_B);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    // Scoreboard: compare decoded bytes against the expected queue, then clear.
    task automatic compare_bytes(input int which, input string tag);
        int n;
        logic [7:0] g;
        n = (which == 0) ? got_a.size() : got_b.size();
        check({tag, "_nbytes"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            g = (which == 0) ? got_a[i] : got_b[i];
            check($sformatf("%s_byte%0d", tag, i), g, exp_q[i]);
        end
        exp_q.delete();
        got_a.delete();
        got_b.delete();
    endtask

    task automatic wait_idle(input int which, input int budget);
        int k;
        k = 0;
        while (k < budget &&
               !((which == 0) ? (busy === 1'b0 && fifo_count === 3'd0)
                              : (busy2 === 1'b0 && fifo_count2 === 3'd0))) begin
            @(negedge hash_clk);
            k++;
        end
        repeat (4) @(negedge hash_clk);
        check("idle_reached", (k < budget), 1);
    endtask

    task automatic do_reset();
        @(negedge hash_clk);
        reset        = 1'b1;
        nonce_valid  = 1'b0;
        nonce_valid2 = 1'b0;
        repeat (3) @(negedge hash_clk);
        reset = 1'b0;
        got_a.delete();
        got_b.delete();
        exp_q.delete();
    endtask

    // Stimulus and checks
    initial begin
        int          cnt;
        int          low;
        int          s0;
        int          gap;
        logic [31:0] fill[5];

        total = 0;
        passed = 0;
        reset = 1'b1;
        nonce_valid = 1'b0;
        nonce_in = '0;
        nonce_valid2 = 1'b0;
        nonce_in2 = '0;

        vecs[0] = '{32'hDEADBEEF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        vecs[1] = '{32'h00000001, 8'h00, 8'h00, 8'h00, 8'h01};
        vecs[2] = '{32'hA5C30F80, 8'hA5, 8'hC3, 8'h0F, 8'h80};
        vecs[3] = '{32'h7E00FF81, 8'h7E, 8'h00, 8'hFF, 8'h81};

        // Reset state
        do_reset();
        check("rst_uart_tx", uart_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_fifo_count", fifo_count, 0);

        // Single nonce: latency and busy length
        @(negedge hash_clk);
        nonce_valid = 1'b1;
        nonce_in = 32'hDEADBEEF;
        @(negedge hash_clk);
        nonce_valid = 1'b0;
        check("lat_count_after_push", fifo_count, 1);
        check("lat_tx_before_load", uart_tx, 1);
        check("lat_busy_before_load", busy, 0);
        @(negedge hash_clk);
        check("lat_busy_load", busy, 1);
        check("lat_count_after_pop", fifo_count, 0);
        check("lat_tx_load", uart_tx, 1);
        cnt = 1;
        @(negedge hash_clk);
        check("lat_tx_start", uart_tx, 0);
        while (busy === 1'b1 && cnt < 400) begin
            cnt++;
            @(negedge hash_clk);
        end
        check("busy_cycles", cnt, 161);
        wait_idle(0, 400);
        push_word(32'hDEADBEEF);
        compare_bytes(0, "single");
        check("single_count_end", fifo_count, 0);

        // Table-driven single words
        for (int i = 0; i < 4; i++) begin
            @(negedge hash_clk);
            nonce_valid = 1'b1;
            nonce_in = vecs[i].nonce;
            @(negedge hash_clk);
            nonce_valid = 1'b0;
            wait_idle(0, 400);
            exp_q.push_back(vecs[i].b0);
            exp_q.push_back(vecs[i].b1);
            exp_q.push_back(vecs[i].b2);
            exp_q.push_back(vecs[i].b3);
            compare_bytes(0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_overflow", i), overflow, 0);
        end

        // Burst of six strobes: fifth fills the FIFO, sixth is dropped
        do_reset();
        @(negedge hash_clk);
        nonce_valid = 1'b1;
        nonce_in = 32'd1;
        for (int i = 2; i <= 6; i++) begin
            @(negedge hash_clk);
            nonce_in = i;
        end
        check("burst_overflow_before6", overflow, 0);
        check("burst_count_before6", fifo_count, 4);
        @(negedge hash_clk);
        nonce_valid = 1'b0;
        check("burst_overflow_after6", overflow, 1);
        check("burst_count_after6", fifo_count, 4);
        wait_idle(0, 1500);
        for (int i = 1; i <= 5; i++) push_word(i);
        compare_bytes(0, "burst");
        check("burst_overflow_sticky", overflow, 1);
        do_reset();
        check("burst_overflow_cleared", overflow, 0);

        // Push into a full FIFO on the pop edge
        fill[0] = 32'hCAFEF00D;
        fill[1] = 32'h01234567;
        fill[2] = 32'h89ABCDEF;
        fill[3] = 32'h0F0F0F0F;
        fill[4] = 32'hF0E1D2C3;
        for (int i = 0; i < 5; i++) begin
            @(negedge hash_clk);
            nonce_valid = 1'b1;
            nonce_in = fill[i];
        end
        @(negedge hash_clk);
        nonce_valid = 1'b0;
        check("fp_count_full", fifo_count, 4);
        check("fp_overflow_full", overflow, 0);
        cnt = 0;
        while (busy === 1'b1 && cnt < 400) begin
            @(negedge hash_clk);
            cnt++;
        end
        check("fp_idle_found", (cnt < 400), 1);
        nonce_valid = 1'b1;
        nonce_in = 32'h12345678;
        @(negedge hash_clk);
        nonce_valid = 1'b0;
        check("fp_busy_load", busy, 1);
        check("fp_count_held", fifo_count, 4);
        check("fp_overflow_clear", overflow, 0);
        wait_idle(0, 1500);
        for (int i = 0; i < 5; i++) push_word(fill[i]);
        push_word(32'h12345678);
        compare_bytes(0, "fullpop");
        check("fp_overflow_end", overflow, 0);

        // Reset during DATA of byte 1 with two words queued
        do_reset();
        @(negedge hash_clk);
        nonce_valid = 1'b1;
        nonce_in = 32'h55000000;
        @(negedge hash_clk);
        nonce_in = 32'h11111111;
        @(negedge hash_clk);
        nonce_in = 32'h22222222;
        @(negedge hash_clk);
        nonce_valid = 1'b0;
        check("rm_count_queued", fifo_count, 2);
        repeat (47) @(negedge hash_clk);
        check("rm_tx_in_data", uart_tx, 0);
        check("rm_busy_in_data", busy, 1);
        reset = 1'b1;
        @(negedge hash_clk);
        check("rm_tx_after", uart_tx, 1);
        check("rm_count_after", fifo_count, 0);
        check("rm_busy_after", busy, 0);
        check("rm_overflow_after", overflow, 0);
        reset = 1'b0;
        low = 0;
        repeat (400) begin
            @(negedge hash_clk);
            if (uart_tx !== 1'b1) low++;
        end
        check("rm_no_frames", low, 0);
        check("rm_busy_quiet", busy, 0);
        exp_q.push_back(8'h55);
        compare_bytes(0, "rm");

        // Back-to-back words at BAUD_DIV=2
        do_reset();
        @(negedge hash_clk);
        nonce_valid2 = 1'b1;
        nonce_in2 = 32'h00000000;
        @(negedge hash_clk);
        nonce_in2 = 32'hFFFFFFFF;
        wave[0] = uart_tx2;
        @(negedge hash_clk);
        nonce_valid2 = 1'b0;
        wave[1] = uart_tx2;
        for (int k = 2; k < 100; k++) begin
            @(negedge hash_clk);
            wave[k] = uart_tx2;
        end
        s0 = -1;
        for (int k = 0; k < 100; k++) begin
            if (s0 < 0 && wave[k] === 1'b0) s0 = k;
        end
        check("b2b_first_start", s0, 2);
        gap = -1;
        if (s0 >= 0 && s0 + 82 < 100) begin
            gap = 0;
            for (int k = s0 + 80; k < 100 && wave[k] === 1'b1; k++) gap++;
        end
        check("b2b_gap_cycles", gap, 2);
        check("b2b_last_stop_high", (s0 >= 0) ? wave[s0 + 79] : 1'bx, 1);
        wait_idle(1, 400);
        push_word(32'h00000000);
        push_word(32'hFFFFFFFF);
        compare_bytes(1, "b2b");
        check("b2b_overflow", overflow2, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
